cmd_ctrl: RTL and testbench

CMD_CTRL -- requirements
Module: cmd_ctrl

---
 rtl/cmd_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cmd_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_ctrl.sv
// Byte-oriented command decoder: turns rx bytes into register-file writes/reads
// and ALU operations, and streams the responses back. Optional macro: CMD_TIMEOUT_EN.
module cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]   WrData,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  output logic                    alu_en,
  output logic [3:0]              alu_fun,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    frame_err
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t                  state, state_nx;
  logic                    wr_en_nx, rd_en_nx, alu_en_nx, tx_valid_nx;
  logic [ADDR_WIDTH-1:0]   address_nx;
  logic [DATA_WIDTH-1:0]   wr_data_nx, tx_data_nx, hi_byte, hi_byte_nx;
  logic [3:0]              alu_fun_nx;
  logic                    timeout;
  logic                    tx_fire;

  assign tx_fire = tx_valid && tx_ready;

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             receiving;

  assign receiving = state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN};

  // Silence is only counted while a frame is being received; any byte restarts it.
  always_comb begin
    cnt_nx  = '0;
    timeout = 1'b0;
    if (receiving && !rx_valid) begin
      if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else                                   cnt_nx  = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      frame_err <= timeout;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign frame_err          = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    wr_en_nx    = 1'b0;
    rd_en_nx    = 1'b0;
    alu_en_nx   = 1'b0;
    address_nx  = address;
    wr_data_nx  = WrData;
    alu_fun_nx  = alu_fun;
    tx_valid_nx = tx_valid;
    tx_data_nx  = tx_data;
    hi_byte_nx  = hi_byte;
    if (timeout) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (rx_valid) begin
          if      (rx_data == CMD_WR)     state_nx = WR_ADDR;
          else if (rx_data == CMD_RD)     state_nx = RD_ADDR;
          else if (rx_data == CMD_ALU_OP) state_nx = ALU_A;
          else if (rx_data == CMD_ALU)    state_nx = ALU_FUN;
        end
        WR_ADDR: if (rx_valid) begin
          address_nx = rx_data[ADDR_WIDTH-1:0];
          state_nx   = WR_DATA;
        end
        WR_DATA: if (rx_valid) begin
          wr_data_nx = rx_data;
          wr_en_nx   = 1'b1;
          state_nx   = IDLE;
        end
        RD_ADDR: if (rx_valid) begin
          address_nx = rx_data[ADDR_WIDTH-1:0];
          rd_en_nx   = 1'b1;
          state_nx   = RD_WAIT;
        end
        RD_WAIT: if (RdData_Valid) begin
          tx_data_nx  = RdData;
          tx_valid_nx = 1'b1;
          state_nx    = TX_HI;
        end
        // Operands land at fixed register addresses 0 and 1 for the ALU.
        ALU_A: if (rx_valid) begin
          address_nx = '0;
          wr_data_nx = rx_data;
          wr_en_nx   = 1'b1;
          state_nx   = ALU_B;
        end
        ALU_B: if (rx_valid) begin
          address_nx = ADDR_WIDTH'(1);
          wr_data_nx = rx_data;
          wr_en_nx   = 1'b1;
          state_nx   = ALU_FUN;
        end
        ALU_FUN: if (rx_valid) begin
          alu_fun_nx = rx_data[3:0];
          alu_en_nx  = 1'b1;
          state_nx   = ALU_WAIT;
        end
        ALU_WAIT: if (alu_out_valid) begin
          tx_data_nx  = alu_out[DATA_WIDTH-1:0];
          hi_byte_nx  = alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_valid_nx = 1'b1;
          state_nx    = TX_LO;
        end
        TX_LO: if (tx_fire) begin
          tx_data_nx = hi_byte;
          state_nx   = TX_HI;
        end
        TX_HI: if (tx_fire) begin
          tx_valid_nx = 1'b0;
          state_nx    = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      alu_en   <= 1'b0;
      address  <= '0;
      WrData   <= '0;
      alu_fun  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      hi_byte  <= '0;
    end else begin
      state    <= state_nx;
      WrEn     <= wr_en_nx;
      RdEn     <= rd_en_nx;
      alu_en   <= alu_en_nx;
      address  <= address_nx;
      WrData   <= wr_data_nx;
      alu_fun  <= alu_fun_nx;
      tx_valid <= tx_valid_nx;
      tx_data  <= tx_data_nx;
      hi_byte  <= hi_byte_nx;
    end
  end

endmodule

// File: tb/tb_cmd_ctrl.sv
// Self-checking bench for cmd_ctrl: directed vector table, randomized frames
// against a frame-level event model, and hand-written reset/stall/timeout sequences.
module tb_cmd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    string           name;
    int              nb;
    logic [0:3][7:0] b;
    int              resp;
    logic [7:0]      rd;
    logic [15:0]     alu;
    int              ne;
    ev_t [0:4]       ev;
  } vec_t;

  localparam int EV_WR = 0, EV_RD = 1, EV_ALU = 2, EV_TX = 3;
  localparam ev_t NOEV = '0;

  logic            clk, rst;
  logic [DW-1:0]   rx_data, RdData, WrData, tx_data;
  logic            rx_valid, RdData_Valid, alu_out_valid, tx_ready;
  logic            WrEn, RdEn, alu_en, tx_valid, frame_err;
  logic [AW-1:0]   address;
  logic [3:0]      alu_fun;
  logic [2*DW-1:0] alu_out;

  int   checks = 0;
  int   errors = 0;
  int   fe_count = 0;
  int   ready_mode = 0;
  ev_t  obs[$];
  ev_t  expq[$];
  vec_t vecs[$];

  cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .WrEn(WrEn), .RdEn(RdEn), .address(address), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Observed transaction log plus the protocol rules that hold on every cycle.
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev  = '0;
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!(tx_valid === 1'b1 && tx_data === data_prev)) begin
          errors++;
          $display("[TB] FAIL tx_hold: got valid %b data %h, required valid 1 data %h",
                   tx_valid, tx_data, data_prev);
        end
      end
      if (WrEn || RdEn) begin
        checks++;
        if (WrEn && RdEn) begin
          errors++;
          $display("[TB] FAIL wr_rd_exclusive: got WrEn %b RdEn %b, required not both", WrEn, RdEn);
        end
      end
      if (WrEn)              obs.push_back(ev(EV_WR, int'(address), int'(WrData)));
      if (RdEn)              obs.push_back(ev(EV_RD, int'(address), 0));
      if (alu_en)            obs.push_back(ev(EV_ALU, 0, int'(alu_fun)));
      if (tx_valid && tx_ready) obs.push_back(ev(EV_TX, 0, int'(tx_data)));
      if (frame_err) fe_count++;
      stall_prev = tx_valid && !tx_ready;
      data_prev  = tx_data;
    end
  end

  function automatic ev_t ev(input int k, input int a, input int d);
    ev_t e;
    e.kind = 2'(k);
    e.a    = 8'(a);
    e.d    = 8'(d);
    return e;
  endfunction

  function automatic vec_t mkVec(input string name, input int nb, input logic [0:3][7:0] b,
                                 input int resp, input logic [7:0] rd, input logic [15:0] alu,
                                 input int ne, input ev_t [0:4] evs);
    vec_t v;
    v.name = name; v.nb = nb; v.b = b; v.resp = resp;
    v.rd = rd; v.alu = alu; v.ne = ne; v.ev = evs;
    return v;
  endfunction

  // Frame-level reference: what a well-formed command must produce, in order.
  function automatic void modelFrame(input vec_t v);
    int b1 = int'(v.b[1]);
    int b2 = int'(v.b[2]);
    int b3 = int'(v.b[3]);
    int al = int'(v.alu);
    case (v.b[0])
      8'hAA: expq.push_back(ev(EV_WR, b1 % (1 << AW), b2));
      8'hBB: begin
        expq.push_back(ev(EV_RD, b1 % (1 << AW), 0));
        expq.push_back(ev(EV_TX, 0, int'(v.rd)));
      end
      8'hCC: begin
        expq.push_back(ev(EV_WR, 0, b1));
        expq.push_back(ev(EV_WR, 1, b2));
        expq.push_back(ev(EV_ALU, 0, b3 % 16));
        expq.push_back(ev(EV_TX, 0, al % 256));
        expq.push_back(ev(EV_TX, 0, al / 256));
      end
      8'hDD: begin
        expq.push_back(ev(EV_ALU, 0, b1 % 16));
        expq.push_back(ev(EV_TX, 0, al % 256));
        expq.push_back(ev(EV_TX, 0, al / 256));
      end
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] junkByte();
    logic [7:0] j;
    do j = 8'($urandom); while (j == 8'hAA || j == 8'hBB || j == 8'hCC || j == 8'hDD);
    return j;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulseRead(input logic [7:0] d);
    RdData       = d;
    RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    RdData       = 8'($urandom);
  endtask

  task automatic pulseAlu(input logic [15:0] d);
    alu_out       = d;
    alu_out_valid = 1'b1;
    tick();
    alu_out_valid = 1'b0;
    alu_out       = 16'($urandom);
  endtask

  task automatic applyStimulus(input vec_t v, input int maxGap, input bit junk);
    for (int i = 0; i < v.nb; i++) begin
      sendByte(v.b[i]);
      if (i < v.nb - 1) repeat ($urandom_range(0, maxGap)) tick();
    end
    if (v.resp != 0) begin
      if (junk) sendByte(8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
      if (v.resp == 1) pulseRead(v.rd);
      else             pulseAlu(v.alu);
      if (junk) sendByte(8'($urandom));
    end
  endtask

  task automatic checkOutput(input string name);
    for (int c = 0; c < 300 && obs.size() < expq.size(); c++) tick();
    repeat (3) tick();
    checks++;
    if (obs.size() != expq.size()) begin
      errors++;
      $display("[TB] FAIL %s event_count: got %0d required %0d", name, obs.size(), expq.size());
    end
    for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
      checks++;
      if (obs[i] !== expq[i]) begin
        errors++;
        $display("[TB] FAIL %s event%0d: got kind %0d a %h d %h, required kind %0d a %h d %h",
                 name, i, obs[i].kind, obs[i].a, obs[i].d, expq[i].kind, expq[i].a, expq[i].d);
      end
    end
    obs.delete();
    expq.delete();
  endtask

  task automatic checkZero(input string name);
    checks++;
    if ({WrEn, RdEn, address, WrData, alu_en, alu_fun, tx_data, tx_valid, frame_err} !== '0) begin
      errors++;
      $display("[TB] FAIL %s outputs: got WrEn %b RdEn %b addr %h wdata %h alu_en %b fun %h tx %h/%b ferr %b, required all 0",
               name, WrEn, RdEn, address, WrData, alu_en, alu_fun, tx_data, tx_valid, frame_err);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  initial begin
    vec_t r;
    int   n;
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; RdData = '0; RdData_Valid = 1'b0;
    alu_out = '0; alu_out_valid = 1'b0;

    vecs.push_back(mkVec("write", 3, {8'hAA, 8'h05, 8'h3C, 8'h00}, 0, 8'h00, 16'h0000, 1,
                         {ev(EV_WR, 5, 8'h3C), NOEV, NOEV, NOEV, NOEV}));
    vecs.push_back(mkVec("read", 2, {8'hBB, 8'h02, 8'h00, 8'h00}, 1, 8'h81, 16'h0000, 2,
                         {ev(EV_RD, 2, 0), ev(EV_TX, 0, 8'h81), NOEV, NOEV, NOEV}));
    vecs.push_back(mkVec("alu_cc", 4, {8'hCC, 8'h07, 8'h03, 8'h00}, 2, 8'h00, 16'h000A, 5,
                         {ev(EV_WR, 0, 8'h07), ev(EV_WR, 1, 8'h03), ev(EV_ALU, 0, 0),
                          ev(EV_TX, 0, 8'h0A), ev(EV_TX, 0, 8'h00)}));
    vecs.push_back(mkVec("junk_then_write", 4, {8'h55, 8'hAA, 8'h01, 8'hFF}, 0, 8'h00, 16'h0000, 1,
                         {ev(EV_WR, 1, 8'hFF), NOEV, NOEV, NOEV, NOEV}));
    vecs.push_back(mkVec("alu_dd", 2, {8'hDD, 8'h1B, 8'h00, 8'h00}, 2, 8'h00, 16'hBEEF, 3,
                         {ev(EV_ALU, 0, 8'h0B), ev(EV_TX, 0, 8'hEF), ev(EV_TX, 0, 8'hBE), NOEV, NOEV}));
    vecs.push_back(mkVec("addr_trunc", 3, {8'hAA, 8'hF7, 8'h00, 8'h00}, 0, 8'h00, 16'h0000, 1,
                         {ev(EV_WR, 7, 8'h00), NOEV, NOEV, NOEV, NOEV}));
    vecs.push_back(mkVec("read_max", 2, {8'hBB, 8'h0F, 8'h00, 8'h00}, 1, 8'hFF, 16'h0000, 2,
                         {ev(EV_RD, 15, 0), ev(EV_TX, 0, 8'hFF), NOEV, NOEV, NOEV}));

    repeat (3) tick();
    checkZero("in_reset");
    rst = 1'b1;
    repeat (2) tick();
    checkZero("after_reset");

    $display("[TB] directed vectors");
    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].ne; i++) expq.push_back(vecs[k].ev[i]);
      applyStimulus(vecs[k], 0, 1'b0);
      checkOutput(vecs[k].name);
    end

    $display("[TB] randomized frames");
    ready_mode = 1;
    for (int f = 0; f < 60; f++) begin
      r.name = "rand";
      r.b    = 32'($urandom);
      r.rd   = 8'($urandom);
      r.alu  = 16'($urandom);
      r.ne   = 0;
      case ($urandom_range(0, 4))
        0:       begin r.b[0] = 8'hAA; r.nb = 3; r.resp = 0; end
        1:       begin r.b[0] = 8'hBB; r.nb = 2; r.resp = 1; end
        2:       begin r.b[0] = 8'hCC; r.nb = 4; r.resp = 2; end
        3:       begin r.b[0] = 8'hDD; r.nb = 2; r.resp = 2; end
        default: begin r.b[0] = junkByte(); r.nb = 1; r.resp = 0; end
      endcase
      modelFrame(r);
      applyStimulus(r, 3, 1'($urandom));
      checkOutput($sformatf("rand%0d", f));
      if ($urandom_range(0, 3) == 0) pulseRead(8'($urandom));
      if ($urandom_range(0, 3) == 0) pulseAlu(16'($urandom));
    end
    checkOutput("stray_responses");

    $display("[TB] tx stall");
    ready_mode = 2;
    r = mkVec("stall", 2, {8'hDD, 8'h05, 8'h00, 8'h00}, 2, 8'h00, 16'h1234, 0,
              {NOEV, NOEV, NOEV, NOEV, NOEV});
    modelFrame(r);
    applyStimulus(r, 0, 1'b0);
    repeat (10) tick();
    checkBit("stall_valid", tx_valid, 1'b1);
    checks++;
    if (tx_data !== 8'h34) begin
      errors++;
      $display("[TB] FAIL stall_data: got %h required 34", tx_data);
    end
    ready_mode = 0;
    checkOutput("stall");

    $display("[TB] reset during ALU_WAIT");
    r = mkVec("pre_rst", 4, {8'hCC, 8'h01, 8'h02, 8'h03}, 0, 8'h00, 16'h0000, 0,
              {NOEV, NOEV, NOEV, NOEV, NOEV});
    modelFrame(r);
    expq.delete();
    expq.push_back(ev(EV_WR, 0, 1));
    expq.push_back(ev(EV_WR, 1, 2));
    expq.push_back(ev(EV_ALU, 0, 3));
    applyStimulus(r, 1, 1'b0);
    checkOutput("pre_rst");
    #2 rst = 1'b0;
    #1 checkZero("rst_alu_wait");
    repeat (2) tick();
    rst = 1'b1;
    pulseAlu(16'hA5A5);
    r = mkVec("post_rst", 4, {8'h05, 8'hAA, 8'h03, 8'h77}, 0, 8'h00, 16'h0000, 0,
              {NOEV, NOEV, NOEV, NOEV, NOEV});
    expq.push_back(ev(EV_WR, 3, 8'h77));
    applyStimulus(r, 1, 1'b0);
    checkOutput("post_rst");

    $display("[TB] reset during transmit");
    ready_mode = 2;
    r = mkVec("rst_tx", 2, {8'hBB, 8'h09, 8'h00, 8'h00}, 1, 8'h5A, 16'h0000, 0,
              {NOEV, NOEV, NOEV, NOEV, NOEV});
    expq.push_back(ev(EV_RD, 9, 0));
    applyStimulus(r, 0, 1'b0);
    repeat (2) tick();
    checkBit("rst_tx_valid_before", tx_valid, 1'b1);
    #2 rst = 1'b0;
    #1 checkZero("rst_tx");
    repeat (2) tick();
    rst = 1'b1;
    ready_mode = 0;
    checkOutput("rst_tx");

`ifdef CMD_TIMEOUT_EN
    $display("[TB] frame timeout");
    fe_count = 0;
    sendByte(8'hAA);
    n = 0;
    while (n < 40 && frame_err !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: got %0d required 16", n);
    end
    tick();
    checkBit("frame_err_one_cycle", frame_err, 1'b0);
    checkOutput("timeout_no_strobe");
    checks++;
    if (fe_count != 1) begin
      errors++;
      $display("[TB] FAIL frame_err_pulses: got %0d required 1", fe_count);
    end
    r = mkVec("after_timeout", 3, {8'hAA, 8'h02, 8'h33, 8'h00}, 0, 8'h00, 16'h0000, 0,
              {NOEV, NOEV, NOEV, NOEV, NOEV});
    expq.push_back(ev(EV_WR, 2, 8'h33));
    applyStimulus(r, 2, 1'b0);
    checkOutput("after_timeout");
`else
    n = 0;
    checks++;
    if (fe_count != n) begin
      errors++;
      $display("[TB] FAIL frame_err_tied: got %0d pulses required 0", fe_count);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
